aes128_round_ctrl: RTL and testbench

- Iterative AES-128 encryption sequencer. It owns the 128-bit state register, the round-key register, the round counter and Rcon generation.
- Each cycle it drives one shared combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) and one combinational key-expansion step.
- It accepts plaintext/key over a valid/ready handshake and returns ciphertext over a valid/ready handshake.
- One block is in flight at a time.

---
 rtl/aes128_round_ctrl.sv | 147 ++++++++++++++
 tb/tb_aes128_round_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes128_round_ctrl
//
// Iterative AES-128 encryption sequencer. Holds the 128-bit cipher state, the
// current round key, the round counter and the Rcon byte. One round is
// performed per clock through an external combinational round datapath
// (SubBytes/ShiftRows/MixColumns/AddRoundKey) and an external combinational
// key-expansion step. One block is in flight at a time.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   in_valid/in_ready plaintext + key handshake (accepted only in IDLE)
//   in_text, in_key   128-bit plaintext / key, byte 0 in [127:120]
//   out_valid/out_ready ciphertext handshake (held in DONE until taken)
//   out_text          ciphertext (zero whenever out_valid is low)
//   busy              high while rounds are being computed
//   round_o           current round number 0..10
//   dp_state_o        state fed to the round datapath
//   dp_key_o          round key fed to the round datapath (= ks_next_i)
//   dp_final_o        final round: datapath skips MixColumns
//   dp_result_i       round datapath result
//   ks_key_o          previous round key fed to key expansion
//   ks_rcon_o         Rcon byte for the current expansion step
//   ks_next_i         expanded next round key
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module aes128_round_ctrl #(
  parameter int NR = 10  // AES-128 only
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy,
  output logic [3:0]   round_o,
  output logic [127:0] dp_state_o,
  output logic [127:0] dp_key_o,
  output logic         dp_final_o,
  input  logic [127:0] dp_result_i,
  output logic [127:0] ks_key_o,
  output logic [7:0]   ks_rcon_o,
  input  logic [127:0] ks_next_i
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the reset is synchronous, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    // NOTE: every next-state signal is given its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;

    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          // Initial AddRoundKey is folded into the accept.
          state_d = in_text ^ in_key;
          key_d   = in_key;
          rcon_d  = 8'h01;
          round_d = 4'd1;
          fsm_d   = S_ROUND;
        end
      end

      S_ROUND: begin
        state_d = dp_result_i;
        key_d   = ks_next_i;
        rcon_d  = xtime(rcon_q);
        if (round_q == LAST_ROUND) begin
          // Round counter parks at the last round while the result waits.
          fsm_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          fsm_d   = S_IDLE;
          round_d = '0;
        end
      end

      default: fsm_d = S_IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 while reset is held, even
  // before the first reset edge has cleared the FSM.
  assign in_ready   = rst_n && (fsm_q == S_IDLE);
  assign out_valid  = (fsm_q == S_DONE);
  assign busy       = (fsm_q == S_ROUND);
  assign out_text   = out_valid ? state_q : '0;
  assign round_o    = round_q;

  assign dp_state_o = state_q;
  assign dp_key_o   = ks_next_i;
  assign dp_final_o = busy && (round_q == LAST_ROUND);
  assign ks_key_o   = key_q;
  assign ks_rcon_o  = rcon_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes128_round_ctrl
//
// Self-checking bench for aes128_round_ctrl. Golden AES round and key
// expansion functions (S-box computed from the GF(2^8) inverse) act as the
// external datapath and as the reference cipher. A per-cycle compare process
// checks handshake, round, Rcon, datapath feed and ciphertext against a
// cycle-count model of the block's life; directed FIPS-197 vectors and a
// randomized phase drive the stimulus.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aes128_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
  logic         busy;
  logic [3:0]   round_o;
  logic [127:0] dp_state_o;
  logic [127:0] dp_key_o;
  logic         dp_final_o;
  logic [127:0] dp_result_i;
  logic [127:0] ks_key_o;
  logic [7:0]   ks_rcon_o;
  logic [127:0] ks_next_i;

  always #5 clk = ~clk;

  aes128_round_ctrl #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_text    (in_text),
    .in_key     (in_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_text   (out_text),
    .busy       (busy),
    .round_o    (round_o),
    .dp_state_o (dp_state_o),
    .dp_key_o   (dp_key_o),
    .dp_final_o (dp_final_o),
    .dp_result_i(dp_result_i),
    .ks_key_o   (ks_key_o),
    .ks_rcon_o  (ks_rcon_o),
    .ks_next_i  (ks_next_i)
  );

  localparam logic [127:0] KC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // ---------------------------------------------------------------- checking
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // ------------------------------------------------------------ golden AES
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse (a^254).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] b = a;
    logic [7:0] s;
    logic [7:0] rot;
    int e = 254;
    while (e != 0) begin
      if (e % 2 == 1) r = gmul(r, b);
      b = gmul(b, b);
      e = e / 2;
    end
    s   = r;
    rot = r;
    for (int i = 0; i < 4; i++) begin
      rot = {rot[6:0], rot[7]};
      s   = s ^ rot;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] rnd_fn(input logic [127:0] st, input logic [127:0] rk,
                                          input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c [4];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        b[row + 4*col] = a[row + 4*((col + row) % 4)];
    if (!fin) begin
      for (int col = 0; col < 4; col++) begin
        for (int row = 0; row < 4; row++) c[row] = b[row + 4*col];
        for (int row = 0; row < 4; row++)
          b[row + 4*col] = gmul(8'h02, c[row]) ^ gmul(8'h03, c[(row+1)%4])
                         ^ c[(row+2)%4] ^ c[(row+3)%4];
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i] ^ rk[127-8*i -: 8];
    return o;
  endfunction

  function automatic logic [127:0] kexp_fn(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0 = k[127:96];
    logic [31:0] w1 = k[95:64];
    logic [31:0] w2 = k[63:32];
    logic [31:0] w3 = k[31:0];
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    t = {w3[23:0], w3[31:24]};
    t = {sbox(t[31:24]) ^ rcon, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] st = pt ^ key;
    logic [127:0] k  = key;
    for (int r = 1; r <= 10; r++) begin
      k  = kexp_fn(k, RC[r-1]);
      st = rnd_fn(st, k, r == 10);
    end
    return st;
  endfunction

  // The golden functions also serve as the DUT's external datapath.
  assign dp_result_i = rnd_fn(dp_state_o, dp_key_o, dp_final_o);
  assign ks_next_i   = kexp_fn(ks_key_o, ks_rcon_o);

  // ------------------------------------------------ model + compare process
  // m_phase: 0 waiting for a block, 1 computing (m_round = 1..10), 2 holding
  // the result. m_st[r]/m_rk[r] are the state/key after r rounds.
  logic [127:0] m_st [11];
  logic [127:0] m_rk [11];
  logic [127:0] m_exp;
  int m_phase = 0;
  int m_round = 0;
  int cyc     = 0;
  bit mdl_on  = 1'b0;
  bit m_rst   = 1'b0;
  int acc_q[$];

  always @(posedge clk) begin
    cyc++;
    m_rst = !rst_n;
    if (!rst_n) begin
      m_phase = 0;
      m_round = 0;
      mdl_on  = 1'b1;
    end else if (mdl_on) begin
      case (m_phase)
        0: if (in_valid) begin
          m_rk[0] = in_key;
          m_st[0] = in_text ^ in_key;
          for (int r = 1; r <= 10; r++) begin
            m_rk[r] = kexp_fn(m_rk[r-1], RC[r-1]);
            m_st[r] = rnd_fn(m_st[r-1], m_rk[r], r == 10);
          end
          m_exp   = m_st[10];
          m_phase = 1;
          m_round = 1;
          acc_q.push_back(cyc);
        end
        1: if (m_round == 10) m_phase = 2; else m_round++;
        2: if (out_ready) begin m_phase = 0; m_round = 0; end
        default: m_phase = 0;
      endcase
    end
    #1;
    if (mdl_on) begin
      check_b("in_ready", in_ready, rst_n && m_phase == 0);
      check_b("out_valid", out_valid, m_phase == 2);
      check_b("busy", busy, m_phase == 1);
      check_i("round_o", int'(round_o), (m_phase == 2) ? 10 : m_round);
      check_b("dp_final_o", dp_final_o, m_phase == 1 && m_round == 10);
      if (m_phase == 1) begin
        check_i("ks_rcon_o", int'(ks_rcon_o), int'(RC[m_round-1]));
        check("dp_state_o", dp_state_o, m_st[m_round-1]);
        check("ks_key_o", ks_key_o, m_rk[m_round-1]);
        check("dp_key_o", dp_key_o, m_rk[m_round]);
      end
      if (m_phase == 2) check("out_text", out_text, m_exp);
      if (m_rst) check("out_text_rst", out_text, 128'h0);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_text  = pt;
    in_key   = key;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("accept");
    @(negedge clk);
    in_valid = 1'b0;
    in_text  = {$urandom, $urandom, $urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Counts falling edges from just after the accept until out_valid.
  task automatic wait_out(output logic [127:0] ct, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("out_valid");
    ct = out_text;
  endtask

  logic [127:0] ct;
  logic [127:0] ct2;
  int lat;
  int n_acc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_text   = '0;
    in_key    = '0;

    // Pin the golden model to hand-known values.
    check_i("pin_sbox00", int'(sbox(8'h00)), 'h63);
    check_i("pin_sbox53", int'(sbox(8'h53)), 'hed);
    check("pin_key1", kexp_fn(KB, 8'h01), 128'ha0fafe1788542cb123a339392a6c7605);
    check("pin_ref_c1", aes_ref(PC1, KC1), CC1);
    check("pin_ref_b", aes_ref(PB, KB), CB);

    check_b("in_ready_in_reset", in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_b("rst_in_ready", in_ready, 1'b1);
    check_b("rst_out_valid", out_valid, 1'b0);
    check_i("rst_round", int'(round_o), 0);
    check_i("rst_rcon", int'(ks_rcon_o), 'h01);

    // out_ready while idle: nothing happens.
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;

    // C.1 with 20 cycles of backpressure and ignored in_valid pulses.
    send(PC1, KC1);
    wait_out(ct, lat);
    check("c1_ct", ct, CC1);
    check_i("c1_latency", lat, 10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_text", out_text, CC1);
      check_b("bp_out_valid", out_valid, 1'b1);
      check_b("bp_in_ready", in_ready, 1'b0);
      in_valid = 1'($urandom % 2);
      in_text  = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_b("bp_released", out_valid, 1'b0);

    // FIPS-197 B with out_ready held high (ignored until DONE).
    out_ready = 1'b1;
    send(PB, KB);
    wait_out(ct, lat);
    check("b_ct", ct, CB);
    check_i("b_latency", lat, 10);
    @(negedge clk);
    check_b("b_released", out_valid, 1'b0);

    // Back-to-back C.1 then B with in_valid and out_ready held high.
    @(negedge clk);
    in_valid = 1'b1;
    in_text  = PC1;
    in_key   = KC1;
    lat = 0;
    while (!in_ready && lat < 40) begin @(negedge clk); lat++; end
    @(negedge clk);
    in_text = PB;
    in_key  = KB;
    wait_out(ct, lat);
    lat = 0;
    @(negedge clk);
    while (!in_ready && lat < 40) begin @(negedge clk); lat++; end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(ct2, lat);
    check("b2b_ct1", ct, CC1);
    check("b2b_ct2", ct2, CB);
    check_i("b2b_interval", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2], 12);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in round 5 with in_valid noise while busy, then a clean C.1.
    send(PC1, KC1);
    in_valid = 1'b1;
    lat = 0;
    while (round_o != 4'd5 && lat < 40) begin @(negedge clk); lat++; end
    check_i("mid_round", int'(round_o), 5);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_b("mid_rst_in_ready", in_ready, 1'b1);
    check_b("mid_rst_out_valid", out_valid, 1'b0);
    check_b("mid_rst_busy", busy, 1'b0);
    check_i("mid_rst_round", int'(round_o), 0);
    send(PC1, KC1);
    wait_out(ct, lat);
    check("after_rst_c1", ct, CC1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Randomized traffic; the compare process checks every cycle.
    n_acc = acc_q.size();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_valid  = ($urandom % 4) == 0;
      in_text   = {$urandom, $urandom, $urandom, $urandom};
      in_key    = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom % 2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (15) @(negedge clk);
    check_b("rand_drained", in_ready, 1'b1);
    check_b("rand_enough_blocks", (acc_q.size() - n_acc) >= 20, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
